pong_match_ctrl: RTL and testbench
==================================

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win (1..15).
REQ-002 Parameter SERVE_FRAMES, default 60, frame_tick count spent in SERVE (1..255).
REQ-003 Parameter SPEED_INIT, default 4, ballSpeed at every serve.
REQ-004 Parameter SPEED_MAX, default 12, ballSpeed saturation ceiling (SPEED_INIT..15).
REQ-005 Parameter HITS_PER_STEP, default 4, paddle hits per ballSpeed increment (1..15).
REQ-006 Parameter PLAYER_SPEED, default 4, constant paddle speed driven out.
REQ-007 CLK  in  1  system clock, sole clock domain.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 frame_tick  in  1  one-cycle pulse per VGA frame.
REQ-010 btns  in  4  raw player buttons, synchronised upstream.
REQ-011 miss_l / miss_r  in  1 each  one-cycle pulse: ball passed left / right paddle.
REQ-012 paddle_hit  in  1  one-cycle pulse: ball bounced off either paddle.
REQ-013 ballSpeed / playerSpeed  out  4 each  speed configuration to game datapath.
REQ-014 ball_reset  out  1  hold ball at centre; motion_en  out  1  ball moves; paddle_en  out  1  paddles move.
REQ-015 serve_dir  out  1  0 = serve toward left, 1 = toward right.
REQ-016 score_l / score_r  out  4 each; game_over  out  1; winner  out  1 (0 = left, 1 = right).

Function
REQ-017 States IDLE, SERVE, PLAY, POINT, GAME_OVER; all outputs registered, updated on CLK rising edge.
REQ-018 start = rising edge of |btns (registered previous value); single-cycle.
REQ-019 IDLE: ball_reset=1, motion_en=0, paddle_en=0; start -> SERVE.
REQ-020 SERVE entry: serve counter cleared, ballSpeed=SPEED_INIT, hit counter=0; ball_reset=1, paddle_en=1, motion_en=0.
REQ-021 SERVE: counter increments per frame_tick; on the tick making count == SERVE_FRAMES -> PLAY next cycle.
REQ-022 PLAY: ball_reset=0, motion_en=1, paddle_en=1.
REQ-023 PLAY miss_l alone: score_r+1, serve_dir=0 (serve toward scored-on player), -> POINT; miss_r alone mirrors (score_l+1, serve_dir=1).
REQ-024 PLAY miss_l and miss_r same cycle: no score, serve_dir unchanged, -> SERVE.
REQ-025 Miss and paddle_hit same cycle: miss wins, hit ignored.
REQ-026 POINT (exactly one cycle, motion_en=0, ball_reset=1): any score == WIN_SCORE -> GAME_OVER, else -> SERVE.
REQ-027 GAME_OVER: game_over=1, winner=side at WIN_SCORE, motion_en=0, paddle_en=0; start -> scores cleared, game_over=0, -> SERVE.
REQ-028 Scores never exceed WIN_SCORE; no wrap.
REQ-029 playerSpeed = PLAYER_SPEED constantly.
REQ-030 Inputs miss_l/miss_r/paddle_hit ignored outside PLAY; start ignored outside IDLE/GAME_OVER.

Reset
REQ-031 rst: state=IDLE, scores 0, ballSpeed=SPEED_INIT, hit counter 0, serve counter 0, ball_reset=1, motion_en=0, paddle_en=0, serve_dir=0, game_over=0, winner=0, button-edge register 0.
REQ-032 rst mid-game overrides all events in that cycle; start not detected on the first post-reset cycle if btns already held.

Configuration
REQ-033 Macro PONG_SPEED_RAMP_EN defined: in PLAY each accepted paddle_hit increments hit counter; hit reaching HITS_PER_STEP wraps counter to 0 and sets ballSpeed=min(ballSpeed+1, SPEED_MAX).
REQ-034 Macro undefined: hit counter absent, ballSpeed fixed at SPEED_INIT, paddle_hit unused.

Structure
REQ-035 Package pong_pkg holds state enum match_state_t, SPEED_W=4, SCORE_W=4 constants.
REQ-036 Sub-module pong_serve_timer (frame_tick counter with clear and done flag) instantiated once.

Verification
REQ-037 rst, btns=0001 pulse -> SERVE; 60 frame_ticks -> motion_en=1 exactly one cycle after 60th tick.
REQ-038 PLAY, miss_l -> score_r=1, serve_dir=0, one POINT cycle, SERVE with ballSpeed=4.
REQ-039 RAMP_EN, 9 paddle_hits in PLAY -> ballSpeed 6; 40 hits -> saturates at 12; next serve -> 4.
REQ-040 score_l=6, miss_r -> score_l=7, game_over=1, winner=0; btns press -> scores 0, SERVE.
REQ-041 miss_l+miss_r same cycle -> scores unchanged, SERVE; miss_r+paddle_hit -> score_l+1, hit counter unchanged.
REQ-042 rst asserted during PLAY with miss_l -> IDLE, score_r=0, ball_reset=1 next cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller.
// Holds the match state enum and the per-state ball/paddle motion decode.
package pong_pkg;

    localparam int SPEED_W     = 4;
    localparam int SCORE_W     = 4;
    localparam int SERVE_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        POINT,
        GAME_OVER
    } match_state_t;

    typedef struct packed {
        logic ball_reset;
        logic motion_en;
        logic paddle_en;
    } motion_ctrl_t;

    // Ball is held at centre everywhere except PLAY; paddles move while a rally is live or pending.
    function automatic motion_ctrl_t motion_ctrl(input match_state_t st);
        motion_ctrl_t c;
        c.ball_reset = 1'b1;
        c.motion_en  = 1'b0;
        c.paddle_en  = 1'b0;
        case (st)
            SERVE: c.paddle_en = 1'b1;
            PLAY: begin
                c.ball_reset = 1'b0;
                c.motion_en  = 1'b1;
                c.paddle_en  = 1'b1;
            end
            POINT: c.paddle_en = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// Counts frame ticks while serving; done stays high once SERVE_FRAMES ticks are seen.
// Clear has priority over tick so the count always starts from zero on a fresh serve.
module pong_serve_timer
    import pong_pkg::*;
#(
    parameter int SERVE_FRAMES = 60
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam logic [SERVE_CNT_W-1:0] TARGET = SERVE_CNT_W'(SERVE_FRAMES);

    logic [SERVE_CNT_W-1:0] count_reg;
    logic [SERVE_CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (tick && (count_reg != TARGET)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign done = (count_reg == TARGET);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve timing, scoring, game-over and ball speed control.
// Define PONG_SPEED_RAMP_EN to ramp ball speed with paddle hits; otherwise speed is fixed.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE     = 7,
    parameter int SERVE_FRAMES  = 60,
    parameter int SPEED_INIT    = 4,
    parameter int SPEED_MAX     = 12,
    parameter int HITS_PER_STEP = 4,
    parameter int PLAYER_SPEED  = 4
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [3:0]         btns,
    input  logic               miss_l,
    input  logic               miss_r,
    input  logic               paddle_hit,
    output logic [SPEED_W-1:0] ballSpeed,
    output logic [SPEED_W-1:0] playerSpeed,
    output logic               ball_reset,
    output logic               motion_en,
    output logic               paddle_en,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
    localparam logic [SPEED_W-1:0] SPD_INIT = SPEED_W'(SPEED_INIT);

    match_state_t       state_reg, state_next;
    logic [SCORE_W-1:0] score_l_reg, score_l_next;
    logic [SCORE_W-1:0] score_r_reg, score_r_next;
    logic [SPEED_W-1:0] speed_reg, speed_next;
    logic               serve_dir_reg, serve_dir_next;
    logic               game_over_reg, game_over_next;
    logic               winner_reg, winner_next;
    motion_ctrl_t       ctrl_reg, ctrl_next;
    logic               btns_prev_reg;
    logic               armed_reg;
    logic               start;
    logic               serve_clear;
    logic               serve_done;

    // armed_reg masks the first post-reset cycle so a button held through reset is not a start.
    assign start       = armed_reg & (|btns) & ~btns_prev_reg;
    assign serve_clear = (state_reg != SERVE);

    pong_serve_timer #(
        .SERVE_FRAMES(SERVE_FRAMES)
    ) u_serve_timer (
        .clk  (CLK),
        .srst (rst),
        .clear(serve_clear),
        .tick (frame_tick),
        .done (serve_done)
    );

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == WIN_S) ? s : s + 1'b1;
    endfunction

    always_comb begin
        state_next     = state_reg;
        score_l_next   = score_l_reg;
        score_r_next   = score_r_reg;
        serve_dir_next = serve_dir_reg;
        game_over_next = game_over_reg;
        winner_next    = winner_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = SERVE;
            end
            SERVE: begin
                if (serve_done) state_next = PLAY;
            end
            PLAY: begin
                // A simultaneous double miss is treated as a void rally.
                if (miss_l && miss_r) begin
                    state_next = SERVE;
                end else if (miss_l) begin
                    score_r_next   = score_inc(score_r_reg);
                    serve_dir_next = 1'b0;
                    state_next     = POINT;
                end else if (miss_r) begin
                    score_l_next   = score_inc(score_l_reg);
                    serve_dir_next = 1'b1;
                    state_next     = POINT;
                end
            end
            POINT: begin
                if ((score_l_reg == WIN_S) || (score_r_reg == WIN_S)) begin
                    state_next     = GAME_OVER;
                    game_over_next = 1'b1;
                    winner_next    = (score_r_reg == WIN_S);
                end else begin
                    state_next = SERVE;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    state_next     = SERVE;
                    score_l_next   = '0;
                    score_r_next   = '0;
                    game_over_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
        ctrl_next = motion_ctrl(state_next);
    end

`ifdef PONG_SPEED_RAMP_EN
    localparam logic [3:0]         HIT_STEP = 4'(HITS_PER_STEP);
    localparam logic [SPEED_W-1:0] SPD_MAX  = SPEED_W'(SPEED_MAX);

    logic [3:0] hit_cnt_reg, hit_cnt_next;

    // Only hits in a rally that did not also end in a miss are counted.
    always_comb begin
        hit_cnt_next = hit_cnt_reg;
        speed_next   = speed_reg;
        if (state_next == SERVE) begin
            hit_cnt_next = '0;
            speed_next   = SPD_INIT;
        end else if ((state_reg == PLAY) && paddle_hit && !miss_l && !miss_r) begin
            if ((hit_cnt_reg + 4'd1) == HIT_STEP) begin
                hit_cnt_next = '0;
                speed_next   = (speed_reg == SPD_MAX) ? speed_reg : speed_reg + 1'b1;
            end else begin
                hit_cnt_next = hit_cnt_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            hit_cnt_reg <= '0;
        end else begin
            hit_cnt_reg <= hit_cnt_next;
        end
    end
`else
    logic unused_paddle_hit;
    logic [31:0] unused_ramp_params;

    assign unused_paddle_hit  = paddle_hit;
    assign unused_ramp_params = 32'(SPEED_MAX) ^ 32'(HITS_PER_STEP);
    assign speed_next         = SPD_INIT;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_reg     <= IDLE;
            score_l_reg   <= '0;
            score_r_reg   <= '0;
            speed_reg     <= SPD_INIT;
            serve_dir_reg <= 1'b0;
            game_over_reg <= 1'b0;
            winner_reg    <= 1'b0;
            ctrl_reg      <= motion_ctrl(IDLE);
            btns_prev_reg <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            score_l_reg   <= score_l_next;
            score_r_reg   <= score_r_next;
            speed_reg     <= speed_next;
            serve_dir_reg <= serve_dir_next;
            game_over_reg <= game_over_next;
            winner_reg    <= winner_next;
            ctrl_reg      <= ctrl_next;
            btns_prev_reg <= |btns;
            armed_reg     <= 1'b1;
        end
    end

    assign ballSpeed   = speed_reg;
    assign playerSpeed = SPEED_W'(PLAYER_SPEED);
    assign ball_reset  = ctrl_reg.ball_reset;
    assign motion_en   = ctrl_reg.motion_en;
    assign paddle_en   = ctrl_reg.paddle_en;
    assign serve_dir   = serve_dir_reg;
    assign score_l     = score_l_reg;
    assign score_r     = score_r_reg;
    assign game_over   = game_over_reg;
    assign winner      = winner_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_pong_match_ctrl;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [3:0] btns = 4'd0;
    logic       miss_l = 1'b0;
    logic       miss_r = 1'b0;
    logic       paddle_hit = 1'b0;
    logic [3:0] ballSpeed, playerSpeed, score_l, score_r;
    logic       ball_reset, motion_en, paddle_en, serve_dir, game_over, winner;

    always #5 CLK = ~CLK;

    pong_match_ctrl dut (
        .CLK        (CLK),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btns       (btns),
        .miss_l     (miss_l),
        .miss_r     (miss_r),
        .paddle_hit (paddle_hit),
        .ballSpeed  (ballSpeed),
        .playerSpeed(playerSpeed),
        .ball_reset (ball_reset),
        .motion_en  (motion_en),
        .paddle_en  (paddle_en),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner)
    );

`ifdef PONG_SPEED_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    typedef enum int {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} st_e;
    typedef struct {
        string       name;
        logic [21:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;

    wire [21:0] act = {ball_reset, motion_en, paddle_en, serve_dir, game_over, winner,
                       ballSpeed, playerSpeed, score_l, score_r};

    // Expected snapshot: {ball_reset, motion_en, paddle_en, serve_dir, game_over, winner, speed, pspeed, sl, sr}
    task automatic expect_st(input string name, input st_e st, input logic [3:0] sl,
                             input logic [3:0] sr, input logic sd, input logic wn,
                             input logic [3:0] spd);
        exp_t e;
        logic br, me, pe, go;
        br = 1'b1; me = 1'b0; pe = 1'b0; go = 1'b0;
        case (st)
            S_SERVE: pe = 1'b1;
            S_PLAY:  begin br = 1'b0; me = 1'b1; pe = 1'b1; end
            S_POINT: pe = 1'b1;
            S_OVER:  go = 1'b1;
            default: ;
        endcase
        e.name = name;
        e.exp  = {br, me, pe, sd, go, wn, spd, 4'd4, sl, sr};
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            total++;
            if (act !== cur.exp) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", cur.name, act, cur.exp);
            end else begin
                $display("ok   %s: %h", cur.name, act);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic serve_to_play(input string name, input logic [3:0] sl,
                                 input logic [3:0] sr, input logic sd);
        frame_tick = 1'b1;
        repeat (60) cyc();
        frame_tick = 1'b0;
        cyc();
        expect_st(name, S_PLAY, sl, sr, sd, 1'b0, 4'd4);
    endtask

    initial begin
        // Reset and start
        repeat (2) cyc();
        expect_st("reset_idle", S_IDLE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);
        rst = 1'b0;
        cyc();
        btns = 4'b0001;
        cyc();
        expect_st("start_serve", S_SERVE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);
        btns = 4'b0000;

        // Serve timing: PLAY exactly one cycle after the 60th tick
        frame_tick = 1'b1;
        repeat (59) cyc();
        expect_st("serve_tick59", S_SERVE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);
        cyc();
        frame_tick = 1'b0;
        expect_st("serve_tick60", S_SERVE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);
        cyc();
        expect_st("play_entry", S_PLAY, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);

        // Speed ramp
        paddle_hit = 1'b1;
        repeat (9) cyc();
        expect_st("hits9", S_PLAY, 4'd0, 4'd0, 1'b0, 1'b0, RAMP ? 4'd6 : 4'd4);
        repeat (31) cyc();
        expect_st("hits40_sat", S_PLAY, 4'd0, 4'd0, 1'b0, 1'b0, RAMP ? 4'd12 : 4'd4);
        paddle_hit = 1'b0;

        // Left miss scores for the right player
        miss_l = 1'b1;
        cyc();
        miss_l = 1'b0;
        expect_st("missl_point", S_POINT, 4'd0, 4'd1, 1'b0, 1'b0, RAMP ? 4'd12 : 4'd4);
        cyc();
        expect_st("missl_serve", S_SERVE, 4'd0, 4'd1, 1'b0, 1'b0, 4'd4);
        serve_to_play("play_after_missl", 4'd0, 4'd1, 1'b0);

        // Double miss voids the rally
        miss_l = 1'b1;
        miss_r = 1'b1;
        cyc();
        miss_l = 1'b0;
        miss_r = 1'b0;
        expect_st("double_miss", S_SERVE, 4'd0, 4'd1, 1'b0, 1'b0, 4'd4);
        serve_to_play("play_after_dbl", 4'd0, 4'd1, 1'b0);

        // Miss beats a same-cycle hit: three prior hits would wrap on a fourth
        paddle_hit = 1'b1;
        repeat (3) cyc();
        paddle_hit = 1'b0;
        expect_st("hits3", S_PLAY, 4'd0, 4'd1, 1'b0, 1'b0, 4'd4);
        miss_r = 1'b1;
        paddle_hit = 1'b1;
        cyc();
        miss_r = 1'b0;
        paddle_hit = 1'b0;
        expect_st("missr_hit_point", S_POINT, 4'd1, 4'd1, 1'b1, 1'b0, 4'd4);
        cyc();
        expect_st("missr_serve", S_SERVE, 4'd1, 4'd1, 1'b1, 1'b0, 4'd4);
        serve_to_play("play_l1", 4'd1, 4'd1, 1'b1);

        // Left player climbs to 6
        for (int k = 2; k <= 6; k++) begin
            miss_r = 1'b1;
            cyc();
            miss_r = 1'b0;
            expect_st($sformatf("point_l%0d", k), S_POINT, 4'(k), 4'd1, 1'b1, 1'b0, 4'd4);
            cyc();
            expect_st($sformatf("serve_l%0d", k), S_SERVE, 4'(k), 4'd1, 1'b1, 1'b0, 4'd4);
            serve_to_play($sformatf("play_l%0d", k), 4'(k), 4'd1, 1'b1);
        end

        // Winning point and game over
        miss_r = 1'b1;
        cyc();
        miss_r = 1'b0;
        expect_st("point_l7", S_POINT, 4'd7, 4'd1, 1'b1, 1'b0, 4'd4);
        cyc();
        expect_st("game_over", S_OVER, 4'd7, 4'd1, 1'b1, 1'b0, 4'd4);
        miss_l = 1'b1;
        cyc();
        miss_l = 1'b0;
        expect_st("over_ignores_miss", S_OVER, 4'd7, 4'd1, 1'b1, 1'b0, 4'd4);
        btns = 4'b0010;
        cyc();
        btns = 4'b0000;
        expect_st("restart_serve", S_SERVE, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4);
        serve_to_play("play_restart", 4'd0, 4'd0, 1'b1);

        // Reset during PLAY overrides a miss
        rst = 1'b1;
        miss_l = 1'b1;
        cyc();
        miss_l = 1'b0;
        expect_st("rst_over_miss", S_IDLE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);

        // Button held through reset is not a start
        btns = 4'b1000;
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        expect_st("held_btn_no_start", S_IDLE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);
        btns = 4'b0000;
        cyc();
        btns = 4'b0100;
        cyc();
        btns = 4'b0000;
        expect_st("fresh_press_serve", S_SERVE, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4);

        repeat (2) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
